// File: rtl/imm_gen_pipe.sv
// RISC-V immediate generator behind a 2-entry result FIFO (head + skid register).
// Define IMMGEN_ZICSR_EN to decode csrr*i encodings as Fmt=CSR with a 5-bit zero-extended uimm.
module imm_gen_pipe #(
  parameter int unsigned XLEN  = 32,
  parameter int unsigned TAG_W = 5
) (
  input  logic             Clk,
  input  logic             Rst_n,
  input  logic             Flush,
  input  logic             InValid,
  output logic             InReady,
  input  logic [31:0]      Ins,
  input  logic [TAG_W-1:0] InTag,
  output logic             OutValid,
  input  logic             OutReady,
  output logic [XLEN-1:0]  Immediate,
  output logic [2:0]       Fmt,
  output logic             Illegal,
  output logic [TAG_W-1:0] OutTag
);

  localparam logic [2:0] FMT_NONE = 3'd0;
  localparam logic [2:0] FMT_I    = 3'd1;
  localparam logic [2:0] FMT_ISH  = 3'd2;
  localparam logic [2:0] FMT_S    = 3'd3;
  localparam logic [2:0] FMT_B    = 3'd4;
  localparam logic [2:0] FMT_U    = 3'd5;
  localparam logic [2:0] FMT_J    = 3'd6;
`ifdef IMMGEN_ZICSR_EN
  localparam logic [2:0] FMT_CSR  = 3'd7;
`endif

  logic [6:0]      w_opc;
  logic [2:0]      w_f3;
  logic            w_is_shift;
  logic [XLEN-1:0] w_imm_i;
  logic [XLEN-1:0] w_imm_s;
  logic [XLEN-1:0] w_imm_b;
  logic [XLEN-1:0] w_imm_u;
  logic [XLEN-1:0] w_imm_j;
  logic [XLEN-1:0] w_imm_sh;
  logic [XLEN-1:0] w_imm_sh5;
  logic [XLEN-1:0] w_dec_imm;
  logic [2:0]      w_dec_fmt;
  logic            w_dec_ill;

  assign w_opc      = Ins[6:0];
  assign w_f3       = Ins[14:12];
  assign w_is_shift = (w_f3 == 3'b001) || (w_f3 == 3'b101);
  assign w_imm_i    = {{(XLEN-12){Ins[31]}}, Ins[31:20]};
  assign w_imm_s    = {{(XLEN-12){Ins[31]}}, Ins[31:25], Ins[11:7]};
  assign w_imm_b    = {{(XLEN-13){Ins[31]}}, Ins[31], Ins[7], Ins[30:25], Ins[11:8], 1'b0};
  assign w_imm_u    = {{(XLEN-32){Ins[31]}}, Ins[31:12], 12'b0};
  assign w_imm_j    = {{(XLEN-21){Ins[31]}}, Ins[31], Ins[19:12], Ins[20], Ins[30:21], 1'b0};
  assign w_imm_sh5  = XLEN'(Ins[24:20]);
  assign w_imm_sh   = (XLEN == 64) ? XLEN'(Ins[25:20]) : w_imm_sh5;

  // Opcode decode; every path lands on a defined format
  always_comb begin
    w_dec_imm = '0;
    w_dec_fmt = FMT_NONE;
    w_dec_ill = 1'b0;
    if (Ins[1:0] != 2'b11) begin
      w_dec_ill = 1'b1;
    end else begin
      case (w_opc)
        7'b0000011, 7'b0001111, 7'b1100111: begin
          w_dec_imm = w_imm_i;
          w_dec_fmt = FMT_I;
        end
        7'b1110011: begin
`ifdef IMMGEN_ZICSR_EN
          if (w_f3[2] && (w_f3[1:0] != 2'b00)) begin
            w_dec_imm = XLEN'(Ins[19:15]);
            w_dec_fmt = FMT_CSR;
          end else begin
            w_dec_imm = w_imm_i;
            w_dec_fmt = FMT_I;
          end
`else
          w_dec_imm = w_imm_i;
          w_dec_fmt = FMT_I;
`endif
        end
        7'b0010011: begin
          if (w_is_shift) begin
            w_dec_imm = w_imm_sh;
            w_dec_fmt = FMT_ISH;
          end else begin
            w_dec_imm = w_imm_i;
            w_dec_fmt = FMT_I;
          end
        end
        7'b0011011: begin
          if (XLEN == 64) begin
            if (w_is_shift) begin
              w_dec_imm = w_imm_sh5;
              w_dec_fmt = FMT_ISH;
            end else begin
              w_dec_imm = w_imm_i;
              w_dec_fmt = FMT_I;
            end
          end else begin
            w_dec_ill = 1'b1;
          end
        end
        7'b0100011: begin
          w_dec_imm = w_imm_s;
          w_dec_fmt = FMT_S;
        end
        7'b1100011: begin
          w_dec_imm = w_imm_b;
          w_dec_fmt = FMT_B;
        end
        7'b0010111, 7'b0110111: begin
          w_dec_imm = w_imm_u;
          w_dec_fmt = FMT_U;
        end
        7'b1101111: begin
          w_dec_imm = w_imm_j;
          w_dec_fmt = FMT_J;
        end
        7'b0110011, 7'b0111011: begin
          w_dec_fmt = FMT_NONE;
        end
        default: begin
          w_dec_ill = 1'b1;
        end
      endcase
    end
  end

  // Head entry drives the outputs directly; skid holds the second entry
  logic [1:0]       r_count;
  logic             r_in_ready;
  logic             r_out_valid;
  logic [XLEN-1:0]  r_imm;
  logic [2:0]       r_fmt;
  logic             r_ill;
  logic [TAG_W-1:0] r_tag;
  logic [XLEN-1:0]  r_sk_imm;
  logic [2:0]       r_sk_fmt;
  logic             r_sk_ill;
  logic [TAG_W-1:0] r_sk_tag;

  logic       w_push;
  logic       w_pop;
  logic [1:0] w_count_nxt;

  assign w_push      = InValid & r_in_ready;
  assign w_pop       = r_out_valid & OutReady;
  assign w_count_nxt = r_count + 2'(w_push) - 2'(w_pop);

  always_ff @(posedge Clk or negedge Rst_n) begin
    if (!Rst_n) begin
      r_count     <= 2'd0;
      r_in_ready  <= 1'b1;
      r_out_valid <= 1'b0;
      r_imm       <= '0;
      r_fmt       <= FMT_NONE;
      r_ill       <= 1'b0;
      r_tag       <= '0;
      r_sk_imm    <= '0;
      r_sk_fmt    <= FMT_NONE;
      r_sk_ill    <= 1'b0;
      r_sk_tag    <= '0;
    end else if (Flush) begin
      r_count     <= 2'd0;
      r_in_ready  <= 1'b1;
      r_out_valid <= 1'b0;
    end else begin
      if (w_pop && (r_count == 2'd2)) begin
        r_imm <= r_sk_imm;
        r_fmt <= r_sk_fmt;
        r_ill <= r_sk_ill;
        r_tag <= r_sk_tag;
      end else if (w_push && ((r_count == 2'd0) || w_pop)) begin
        r_imm <= w_dec_imm;
        r_fmt <= w_dec_fmt;
        r_ill <= w_dec_ill;
        r_tag <= InTag;
      end
      if (w_push && !w_pop && (r_count == 2'd1)) begin
        r_sk_imm <= w_dec_imm;
        r_sk_fmt <= w_dec_fmt;
        r_sk_ill <= w_dec_ill;
        r_sk_tag <= InTag;
      end
      r_count     <= w_count_nxt;
      r_out_valid <= (w_count_nxt != 2'd0);
      r_in_ready  <= (w_count_nxt != 2'd2);
    end
  end

  assign InReady   = r_in_ready;
  assign OutValid  = r_out_valid;
  assign Immediate = r_imm;
  assign Fmt       = r_fmt;
  assign Illegal   = r_ill;
  assign OutTag    = r_tag;

endmodule

// File: tb/tb_imm_gen_pipe.sv
// Directed bench for imm_gen_pipe: XLEN=32 and XLEN=64 instances share one stimulus stream.
module tb_imm_gen_pipe;

  logic        clk = 1'b0;
  logic        rst_n;
  logic        flush;
  logic        in_valid;
  logic [31:0] ins;
  logic [4:0]  in_tag;
  logic        out_ready;

  logic        in_ready32, out_valid32, ill32;
  logic [31:0] imm32;
  logic [2:0]  fmt32;
  logic [4:0]  tag32;
  logic        in_ready64, out_valid64, ill64;
  logic [63:0] imm64;
  logic [2:0]  fmt64;
  logic [4:0]  tag64;

  int n_checks = 0;
  int n_errors = 0;

  always #5 clk = ~clk;

  imm_gen_pipe #(.XLEN(32), .TAG_W(5)) u_dut32 (
    .Clk(clk), .Rst_n(rst_n), .Flush(flush), .InValid(in_valid), .InReady(in_ready32),
    .Ins(ins), .InTag(in_tag), .OutValid(out_valid32), .OutReady(out_ready),
    .Immediate(imm32), .Fmt(fmt32), .Illegal(ill32), .OutTag(tag32)
  );

  imm_gen_pipe #(.XLEN(64), .TAG_W(5)) u_dut64 (
    .Clk(clk), .Rst_n(rst_n), .Flush(flush), .InValid(in_valid), .InReady(in_ready64),
    .Ins(ins), .InTag(in_tag), .OutValid(out_valid64), .OutReady(out_ready),
    .Immediate(imm64), .Fmt(fmt64), .Illegal(ill64), .OutTag(tag64)
  );

  typedef struct {
    logic [31:0] ins;
    logic [31:0] imm32;
    logic [2:0]  fmt32;
    logic        ill32;
    logic [63:0] imm64;
    logic [2:0]  fmt64;
    logic        ill64;
  } vec_t;

  localparam int NV = 20;
  vec_t vecs[NV];

  function automatic vec_t mk(input logic [31:0] i, input logic [31:0] m32, input logic [2:0] f32,
                              input logic l32, input logic [63:0] m64, input logic [2:0] f64,
                              input logic l64);
    vec_t v;
    v.ins = i; v.imm32 = m32; v.fmt32 = f32; v.ill32 = l32;
    v.imm64 = m64; v.fmt64 = f64; v.ill64 = l64;
    return v;
  endfunction

  task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_errors++;
      $display("FAIL %s: got %h expected %h", name, act, exp);
    end
  endtask

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  initial begin
    vecs[0]  = mk(32'hFFF00093, 32'hFFFFFFFF, 3'd1, 1'b0, 64'hFFFFFFFFFFFFFFFF, 3'd1, 1'b0);
    vecs[1]  = mk(32'h43F05093, 32'h0000001F, 3'd2, 1'b0, 64'd63,               3'd2, 1'b0);
    vecs[2]  = mk(32'h0010009B, 32'h00000000, 3'd0, 1'b1, 64'd1,                3'd1, 1'b0);
    vecs[3]  = mk(32'h0230109B, 32'h00000000, 3'd0, 1'b1, 64'd3,                3'd2, 1'b0);
    vecs[4]  = mk(32'h800000EF, 32'hFFF00000, 3'd6, 1'b0, 64'hFFFFFFFFFFF00000, 3'd6, 1'b0);
    vecs[5]  = mk(32'h0000002B, 32'h00000000, 3'd0, 1'b1, 64'd0,                3'd0, 1'b1);
    vecs[6]  = mk(32'hFFF00090, 32'h00000000, 3'd0, 1'b1, 64'd0,                3'd0, 1'b1);
    vecs[7]  = mk(32'hFE112E23, 32'hFFFFFFFC, 3'd3, 1'b0, 64'hFFFFFFFFFFFFFFFC, 3'd3, 1'b0);
    vecs[8]  = mk(32'h00000863, 32'h00000010, 3'd4, 1'b0, 64'h10,               3'd4, 1'b0);
    vecs[9]  = mk(32'h800000E3, 32'hFFFFF800, 3'd4, 1'b0, 64'hFFFFFFFFFFFFF800, 3'd4, 1'b0);
    vecs[10] = mk(32'h800000B7, 32'h80000000, 3'd5, 1'b0, 64'hFFFFFFFF80000000, 3'd5, 1'b0);
    vecs[11] = mk(32'h12345017, 32'h12345000, 3'd5, 1'b0, 64'h12345000,         3'd5, 1'b0);
    vecs[12] = mk(32'h002081B3, 32'h00000000, 3'd0, 1'b0, 64'd0,                3'd0, 1'b0);
    vecs[13] = mk(32'h0000003B, 32'h00000000, 3'd0, 1'b0, 64'd0,                3'd0, 1'b0);
    vecs[14] = mk(32'h80002083, 32'hFFFFF800, 3'd1, 1'b0, 64'hFFFFFFFFFFFFF800, 3'd1, 1'b0);
    vecs[15] = mk(32'h0FF0000F, 32'h000000FF, 3'd1, 1'b0, 64'hFF,               3'd1, 1'b0);
    vecs[16] = mk(32'hFFC08067, 32'hFFFFFFFC, 3'd1, 1'b0, 64'hFFFFFFFFFFFFFFFC, 3'd1, 1'b0);
    vecs[17] = mk(32'h30029073, 32'h00000300, 3'd1, 1'b0, 64'h300,              3'd1, 1'b0);
`ifdef IMMGEN_ZICSR_EN
    vecs[18] = mk(32'h3002D073, 32'h00000005, 3'd7, 1'b0, 64'd5,                3'd7, 1'b0);
`else
    vecs[18] = mk(32'h3002D073, 32'h00000300, 3'd1, 1'b0, 64'h300,              3'd1, 1'b0);
`endif
    vecs[19] = mk(32'h00000073, 32'h00000000, 3'd1, 1'b0, 64'd0,                3'd1, 1'b0);

    rst_n = 1'b0; flush = 1'b0; in_valid = 1'b0; ins = 32'h0; in_tag = 5'd0; out_ready = 1'b0;

    // Reset state
    #12;
    chk("rst out_valid", 64'(out_valid32), 64'd0);
    chk("rst imm",       64'(imm32),       64'd0);
    chk("rst fmt",       64'(fmt32),       64'd0);
    chk("rst illegal",   64'(ill32),       64'd0);
    chk("rst tag",       64'(tag32),       64'd0);
    @(negedge clk) rst_n = 1'b1;
    step();
    chk("post-rst in_ready",  64'(in_ready32),  64'd1);
    chk("post-rst out_valid", 64'(out_valid32), 64'd0);

    // Streaming decode table, one result per cycle
    out_ready = 1'b1;
    for (int i = 0; i < NV; i++) begin
      @(negedge clk);
      in_valid = 1'b1;
      ins      = vecs[i].ins;
      in_tag   = 5'(i);
      step();
      chk($sformatf("v%0d out_valid32", i), 64'(out_valid32), 64'd1);
      chk($sformatf("v%0d tag32", i),       64'(tag32),       64'(i));
      chk($sformatf("v%0d imm32", i),       64'(imm32),       64'(vecs[i].imm32));
      chk($sformatf("v%0d fmt32", i),       64'(fmt32),       64'(vecs[i].fmt32));
      chk($sformatf("v%0d ill32", i),       64'(ill32),       64'(vecs[i].ill32));
      chk($sformatf("v%0d out_valid64", i), 64'(out_valid64), 64'd1);
      chk($sformatf("v%0d imm64", i),       imm64,            vecs[i].imm64);
      chk($sformatf("v%0d fmt64", i),       64'(fmt64),       64'(vecs[i].fmt64));
      chk($sformatf("v%0d ill64", i),       64'(ill64),       64'(vecs[i].ill64));
    end
    @(negedge clk) in_valid = 1'b0;
    step();
    chk("drain out_valid", 64'(out_valid32), 64'd0);
    chk("drain in_ready",  64'(in_ready32),  64'd1);

    // Backpressure: three back-to-back offers against a stalled consumer
    @(negedge clk);
    out_ready = 1'b0; in_valid = 1'b1; ins = 32'h00100093; in_tag = 5'd1;
    step();
    chk("bp1 in_ready", 64'(in_ready32), 64'd1);
    chk("bp1 tag",      64'(tag32),      64'd1);
    @(negedge clk) begin ins = 32'h00200093; in_tag = 5'd2; end
    step();
    chk("bp2 in_ready", 64'(in_ready32), 64'd0);
    chk("bp2 tag",      64'(tag32),      64'd1);
    chk("bp2 imm",      64'(imm32),      64'd1);
    @(negedge clk) begin ins = 32'h00300093; in_tag = 5'd3; end
    step();
    chk("bp3 in_ready",  64'(in_ready32),  64'd0);
    chk("bp3 out_valid", 64'(out_valid32), 64'd1);
    chk("bp3 tag stable", 64'(tag32),      64'd1);
    @(negedge clk) out_ready = 1'b1;
    step();
    chk("bp4 tag",      64'(tag32),      64'd2);
    chk("bp4 imm",      64'(imm32),      64'd2);
    chk("bp4 in_ready", 64'(in_ready32), 64'd1);
    step();
    chk("bp5 tag",       64'(tag32),       64'd3);
    chk("bp5 imm",       64'(imm32),       64'd3);
    chk("bp5 out_valid", 64'(out_valid32), 64'd1);
    @(negedge clk) in_valid = 1'b0;
    step();
    chk("bp6 out_valid", 64'(out_valid32), 64'd0);

    // Flush with FIFO full and a simultaneous offer
    @(negedge clk);
    out_ready = 1'b0; in_valid = 1'b1; ins = 32'h00100093; in_tag = 5'd4;
    step();
    @(negedge clk) in_tag = 5'd5;
    step();
    chk("fl full in_ready", 64'(in_ready32), 64'd0);
    @(negedge clk) begin flush = 1'b1; in_tag = 5'd6; end
    step();
    chk("fl out_valid", 64'(out_valid32), 64'd0);
    chk("fl in_ready",  64'(in_ready32),  64'd1);
    @(negedge clk) begin flush = 1'b0; in_valid = 1'b0; end
    step();
    chk("fl push dropped", 64'(out_valid32), 64'd0);

    // Asynchronous reset while a result is held
    @(negedge clk);
    in_valid = 1'b1; ins = 32'h0000002B; in_tag = 5'd7;
    step();
    chk("mr held valid",   64'(out_valid32), 64'd1);
    chk("mr held illegal", 64'(ill32),       64'd1);
    #2 rst_n = 1'b0;
    #1;
    chk("mr out_valid", 64'(out_valid32), 64'd0);
    chk("mr illegal",   64'(ill32),       64'd0);
    chk("mr tag",       64'(tag32),       64'd0);
    chk("mr imm64",     imm64,            64'd0);
    @(negedge clk) begin rst_n = 1'b1; in_valid = 1'b0; end
    step();
    chk("mr post out_valid", 64'(out_valid32), 64'd0);
    chk("mr post in_ready",  64'(in_ready32),  64'd1);

    $display("CHECKS %0d ERRORS %0d", n_checks, n_errors);
    $finish;
  end

endmodule
